mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port Start_E, input, 1: a MULT/MULTU/DIV/DIVU instruction occupies the Execute stage.
REQ-004 SHALL have port Op_E, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports SrcA_E and SrcB_E, input, 32 each: rs and rs/rt operands, already forwarded.
REQ-006 SHALL have port ReadHiLo_D, input, 1: MFHI/MFLO in Decode.
REQ-007 SHALL have port MdInstr_D, input, 1: a mult/div instruction in Decode.
REQ-008 SHALL have port StallMD, output, 1: stalls PC and Decode and flushes Execute; OR'd with hazard-unit stalls.
REQ-009 SHALL have port Busy, output, 1: high whenever state is not IDLE.
REQ-010 SHALL have ports Hi and Lo, output, 32 each: architectural HI/LO registers.
REQ-011 SHALL have port DivZero, output, 1: one-cycle pulse on completion of a DIV/DIVU with divisor 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and FIX; Busy = (state != IDLE).
REQ-013 IDLE with Start_E=1 SHALL, at the edge: capture |SrcA_E|, |SrcB_E| (raw values for unsigned ops), the result sign, Op_E and the original SrcA_E; clear the 5-bit counter; enter RUN.
REQ-014 RUN SHALL perform one iteration per cycle: shift-add multiply for ops 00/01, restoring divide for ops 10/11.
REQ-015 Counter SHALL increment each RUN cycle; RUN SHALL advance to FIX on the edge where counter = 31, giving exactly 32 RUN cycles.
REQ-016 FIX SHALL apply sign correction, write Hi and Lo at its edge, and return to IDLE.
REQ-017 Latency: Hi/Lo SHALL show the new result 33 rising edges after the capture edge; Busy SHALL be low in the cycle after that.
REQ-018 Multiply: {Hi,Lo} SHALL equal the 64-bit product, two's-complement for MULT, unsigned for MULTU.
REQ-019 Divide: Lo SHALL be the quotient truncated toward zero; Hi SHALL be the remainder carrying the dividend's sign.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield Lo=0x80000000, Hi=0x00000000 with no flag.
REQ-021 Divisor 0 (DIV or DIVU) SHALL yield Lo=0xFFFFFFFF, Hi = the captured original SrcA_E, and DivZero=1 for the single cycle after the FIX edge.
REQ-022 StallMD SHALL equal (ReadHiLo_D | MdInstr_D) & (Busy | Start_E), combinationally.
REQ-023 Start_E while Busy SHALL be ignored; operands and state SHALL NOT change.
REQ-024 Hi/Lo SHALL hold their values in every cycle other than the FIX edge.
REQ-025 In IDLE with Start_E=0, the block SHALL change no state.

Reset
REQ-026 rst=1 SHALL, asynchronously and in any state including mid-RUN, force: state=IDLE, counter=0, Hi=0, Lo=0, DivZero=0, Busy=0, all internal operand registers=0.
REQ-027 After rst deasserts, a new Start_E SHALL be accepted at the first rising edge at which it is sampled high.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 33 edges after capture: Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for exactly 33 cycles.
REQ-029 MULT 0xFFFFFFFD (-3) x 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
REQ-030 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 100/7 -> Lo=0x0000000E, Hi=0x00000002.
REQ-031 DIVU 0x00000064 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000064; DivZero high for exactly one cycle.
REQ-032 ReadHiLo_D=1 held from the Start_E cycle onward -> StallMD=1 in the Start_E cycle and all 33 busy cycles, StallMD=0 in the first IDLE cycle; Start_E pulsed mid-RUN -> result unchanged.
REQ-033 rst asserted at RUN counter=10 -> Busy=0, Hi=Lo=0 immediately without a clock edge; a following MULTU 6x7 -> Lo=0x0000002A, Hi=0.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative MIPS HI/LO multiply/divide unit: 32 shift-add or restoring-divide
// steps on magnitudes, then a sign-fix cycle that writes Hi/Lo.
module mdu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start_E,
  input  logic [1:0]  Op_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  input  logic        ReadHiLo_D,
  input  logic        MdInstr_D,
  output logic        StallMD,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivZero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [31:0] b_mag, orig_a;
  logic        neg_q, neg_r;
  // rem is the running upper half (partial product or partial remainder),
  // lo_q the multiplier/dividend being shifted out and quotient shifted in.
  logic [32:0] rem;
  logic [31:0] lo_q;

  logic        sgn_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, shifted;
  logic [33:0] diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix;

  assign Busy    = (state != IDLE);
  assign StallMD = (ReadHiLo_D | MdInstr_D) & (Busy | Start_E);

  always_comb begin
    sgn_op   = ~Op_E[0];
    abs_a    = (sgn_op && SrcA_E[31]) ? -SrcA_E : SrcA_E;
    abs_b    = (sgn_op && SrcB_E[31]) ? -SrcB_E : SrcB_E;
    mul_sum  = {1'b0, rem[31:0]} + (lo_q[0] ? {1'b0, b_mag} : 33'd0);
    shifted  = {rem[31:0], lo_q[31]};
    diff     = {1'b0, shifted} - {2'b00, b_mag};
    prod     = {rem[31:0], lo_q};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -lo_q : lo_q;
    r_fix    = neg_r ? -rem[31:0] : rem[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      op      <= 2'd0;
      b_mag   <= 32'd0;
      orig_a  <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem     <= 33'd0;
      lo_q    <= 32'd0;
      Hi      <= 32'd0;
      Lo      <= 32'd0;
      DivZero <= 1'b0;
    end else begin
      DivZero <= 1'b0;
      case (state)
        IDLE: if (Start_E) begin
          op     <= Op_E;
          b_mag  <= abs_b;
          orig_a <= SrcA_E;
          lo_q   <= abs_a;
          rem    <= 33'd0;
          cnt    <= 5'd0;
          neg_q  <= sgn_op & (SrcA_E[31] ^ SrcB_E[31]);
          neg_r  <= sgn_op & Op_E[1] & SrcA_E[31];
          state  <= RUN;
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (!op[1]) begin
            rem  <= {1'b0, mul_sum[32:1]};
            lo_q <= {mul_sum[0], lo_q[31:1]};
          end else if (!diff[33]) begin
            rem  <= diff[32:0];
            lo_q <= {lo_q[30:0], 1'b1};
          end else begin
            rem  <= shifted;
            lo_q <= {lo_q[30:0], 1'b0};
          end
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (!op[1]) begin
            Hi <= prod_fix[63:32];
            Lo <= prod_fix[31:0];
          end else if (b_mag == 32'd0) begin
            Hi      <= orig_a;
            Lo      <= 32'hFFFF_FFFF;
            DivZero <= 1'b1;
          end else begin
            Hi <= r_fix;
            Lo <= q_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected Hi/Lo/DivZero queued at issue,
// popped and compared when the unit drops Busy.
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        Start_E, ReadHiLo_D, MdInstr_D;
  logic [1:0]  Op_E;
  logic [31:0] SrcA_E, SrcB_E;
  logic        StallMD, Busy, DivZero;
  logic [31:0] Hi, Lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mdu_sequencer dut (
    .clk(clk), .rst(rst), .Start_E(Start_E), .Op_E(Op_E),
    .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .ReadHiLo_D(ReadHiLo_D),
    .MdInstr_D(MdInstr_D), .StallMD(StallMD), .Busy(Busy),
    .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.dz = 1'b0;
    case (op)
      2'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
        end else if (op == 2'd2) begin
          p = sa / sb; r.lo = p[31:0];
          p = sa % sb; r.hi = p[31:0];
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Issue one op, follow it through Busy, then compare against the scoreboard.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input res_t exp, input logic rd, input logic pulse);
    res_t e;
    logic [31:0] prev_lo;
    int busy_cyc, stall_cyc, dz_cyc;
    @(negedge clk);
    prev_lo    = Lo;
    Start_E    = 1'b1;
    Op_E       = op;
    SrcA_E     = a;
    SrcB_E     = b;
    ReadHiLo_D = rd;
    sb_q.push_back(exp);
    #1 chk("stall_start", StallMD, rd);
    @(posedge clk);
    #1 Start_E = 1'b0;
    busy_cyc = 0; stall_cyc = 0; dz_cyc = 0;
    while (Busy && busy_cyc < 100) begin
      busy_cyc++;
      stall_cyc += StallMD;
      if (busy_cyc == 33) chk("lo_hold", Lo, prev_lo);
      if (pulse && busy_cyc == 11) begin
        Start_E = 1'b1; Op_E = ~op; SrcA_E = $urandom; SrcB_E = $urandom;
      end
      if (pulse && busy_cyc == 12) Start_E = 1'b0;
      @(posedge clk);
      #1 dz_cyc += DivZero;
    end
    chk("busy_cycles", busy_cyc, 33);
    chk("stall_cycles", stall_cyc, rd ? 33 : 0);
    chk("stall_idle", StallMD, 1'b0);
    e = sb_q.pop_front();
    chk("hi", Hi, e.hi);
    chk("lo", Lo, e.lo);
    @(posedge clk);
    #1 dz_cyc += DivZero;
    chk("divzero_cycles", dz_cyc, e.dz ? 1 : 0);
    ReadHiLo_D = 1'b0;
  endtask

  task automatic run_rand(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    run_op(op, a, b, model(op, a, b), 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; Start_E = 1'b0; ReadHiLo_D = 1'b0; MdInstr_D = 1'b0;
    Op_E = 2'd0; SrcA_E = 32'd0; SrcB_E = 32'd0;
    #12;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_dz", DivZero, 1'b0);
    chk("rst_stall", StallMD, 1'b0);
    @(negedge clk) rst = 1'b0;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}, 1'b0, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}, 1'b0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 1'b0, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, '{32'h0000_0002, 32'h0000_000E, 1'b0}, 1'b1, 1'b1);
    run_op(2'd3, 32'h0000_0064, 32'd0, '{32'h0000_0064, 32'hFFFF_FFFF, 1'b1}, 1'b0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h8000_0000, 1'b0}, 1'b1, 1'b0);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1}, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) run_rand(i[1:0], $urandom, (i % 5 == 4) ? 32'd0 + $urandom_range(1, 9) : $urandom);

    // Abort a MULTU mid-run with an async reset.
    @(negedge clk);
    Start_E = 1'b1; Op_E = 2'd1; SrcA_E = 32'h1234_5678; SrcB_E = 32'h9ABC_DEF0; MdInstr_D = 1'b1;
    #1 chk("stall_mdinstr", StallMD, 1'b1);
    @(posedge clk);
    #1 Start_E = 1'b0; MdInstr_D = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(2'd1, 32'd6, 32'd7, '{32'h0000_0000, 32'h0000_002A, 1'b0}, 1'b0, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
